// File: rtl/aes_round_engine_if.sv
// Handshake and round-key bus of the iterative AES round engine.
//   in_valid/in_ready/in_encrypt/in_block : block input handshake
//   key_idx/round_key                     : round-key request, answered combinationally
//   out_valid/out_ready/out_block         : result output handshake
//   busy                                  : engine is iterating rounds
// The slave modport is the engine side; master is the mode-logic/key-store side.
interface aes_round_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_encrypt;
  logic [127:0] in_block;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;

  modport slave (
    input  in_valid, in_encrypt, in_block, round_key, out_ready,
    output in_ready, key_idx, out_valid, out_block, busy
  );

  modport master (
    output in_valid, in_encrypt, in_block, round_key, out_ready,
    input  in_ready, key_idx, out_valid, out_block, busy
  );
endinterface

// File: rtl/aes_round_engine.sv
// Iterative AES cipher core: one round datapath reused for NR cycles per block.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : aes_round_engine_if.slave (block in, round-key request, block out, busy)
// Byte i of a 128-bit block is bits [127-8i -: 8]; state row r, column c is byte r+4c.
module aes_round_engine #(
  parameter int NR = 10
) (
  input logic               clk,
  input logic               rst_n,
  aes_round_engine_if.slave bus
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_engine: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  // ---------------- GF(2^8) and round-step helpers ----------------
  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] ginv(logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h01;
    pw  = a;
    for (int i = 0; i < 7; i++) begin
      pw  = gmul(pw, pw);
      acc = gmul(acc, pw);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(logic [7:0] a);
    logic [7:0] v;
    v = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(v);
  endfunction

  function automatic logic [127:0] sub_bytes(logic [127:0] s, logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r rotates left by r columns (right for the inverse).
  function automatic logic [127:0] shift_rows(logic [127:0] s, logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(logic [127:0] s, logic inv);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      if (!inv)
        o[127-32*c -: 32] = {
          xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
          a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
          a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
          xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      else
        o[127-32*c -: 32] = {
          gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
          gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
          gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
          gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(logic [127:0] s, logic [127:0] k, logic last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
    if (!last) t = mix_columns(t, 1'b0);
    return t ^ k;
  endfunction

  // Direct inverse-cipher ordering: round keys are used untransformed.
  function automatic logic [127:0] dec_round(logic [127:0] s, logic [127:0] k, logic last);
    logic [127:0] t;
    t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
    if (!last) t = mix_columns(t, 1'b1);
    return t;
  endfunction

  // ---------------- control and state ----------------
  state_e       state_q, state_d;
  logic [3:0]   r_q, r_d;
  logic         enc_q, enc_d;
  logic [127:0] blk_q, blk_d;
  logic         in_ready;
  logic         accept;
  logic         last;
  logic [127:0] round_res;

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    enc_d    = enc_q;
    blk_d    = blk_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    accept   = bus.in_valid && in_ready;
    last     = (r_q == NR_L);

    if (state_q == ROUND) bus.key_idx = enc_q ? r_q : NR_L - r_q;
    else                  bus.key_idx = bus.in_encrypt ? 4'd0 : NR_L;

    round_res = enc_q ? enc_round(blk_q, bus.round_key, last)
                      : dec_round(blk_q, bus.round_key, last);

    case (state_q)
      ROUND: begin
        blk_d = round_res;
        r_d   = r_q + 4'd1;
        if (last) begin
          state_d = DONE;
          r_d     = r_q;
        end
      end
      DONE: begin
        if (bus.out_ready && !bus.in_valid) state_d = IDLE;
      end
      default: ;
    endcase

    // Accept overrides the DONE drain so back-to-back blocks lose no cycle.
    if (accept) begin
      blk_d   = bus.in_block ^ bus.round_key;
      enc_d   = bus.in_encrypt;
      r_d     = 4'd1;
      state_d = ROUND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= 4'd0;
      enc_q   <= 1'b1;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      enc_q   <= enc_d;
      blk_q   <= blk_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_block = blk_q;
  assign bus.busy      = (state_q == ROUND);

endmodule

// File: tb/tb_aes_round_engine.sv
module tb_aes_round_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_encrypt = 1'b1;
  logic         out_ready = 1'b1;
  logic [127:0] in_block = '0;
  logic [127:0] ks [0:2][0:14];
  int           sel = 0;

  aes_round_engine_if b10();
  aes_round_engine_if b12();
  aes_round_engine_if b14();

  aes_round_engine #(.NR(10)) u10 (.clk(clk), .rst_n(rst_n), .bus(b10));
  aes_round_engine #(.NR(12)) u12 (.clk(clk), .rst_n(rst_n), .bus(b12));
  aes_round_engine #(.NR(14)) u14 (.clk(clk), .rst_n(rst_n), .bus(b14));

  assign b10.in_valid = in_valid;   assign b12.in_valid = in_valid;   assign b14.in_valid = in_valid;
  assign b10.in_encrypt = in_encrypt; assign b12.in_encrypt = in_encrypt; assign b14.in_encrypt = in_encrypt;
  assign b10.in_block = in_block;   assign b12.in_block = in_block;   assign b14.in_block = in_block;
  assign b10.out_ready = out_ready; assign b12.out_ready = out_ready; assign b14.out_ready = out_ready;
  assign b10.round_key = ks[0][b10.key_idx];
  assign b12.round_key = ks[1][b12.key_idx];
  assign b14.round_key = ks[2][b14.key_idx];

  logic         c_ir, c_ov, c_busy;
  logic [3:0]   c_ki;
  logic [127:0] c_ob;
  always_comb begin
    c_ir = b10.in_ready; c_ov = b10.out_valid; c_busy = b10.busy; c_ki = b10.key_idx; c_ob = b10.out_block;
    if (sel == 1) begin
      c_ir = b12.in_ready; c_ov = b12.out_valid; c_busy = b12.busy; c_ki = b12.key_idx; c_ob = b12.out_block;
    end else if (sel == 2) begin
      c_ir = b14.in_ready; c_ov = b14.out_valid; c_busy = b14.busy; c_ki = b14.key_idx; c_ob = b14.out_block;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (FIPS-197 textbook form) ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    int acc, x, y;
    acc = 0; x = a; y = b;
    while (y != 0) begin
      if (y & 1) acc = acc ^ x;
      x = x << 1;
      if (x & 256) x = x ^ 'h11b;
      y = y >> 1;
    end
    return acc[7:0];
  endfunction

  function automatic logic [7:0] bt(logic [127:0] v, int r, int c);
    return v[127-8*(4*c+r) -: 8];
  endfunction

  function automatic logic [127:0] m_sub(logic [127:0] v, bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isb[v[127-8*i -: 8]] : sb[v[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] m_shift(logic [127:0] v, bit inv);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = bt(v, r, inv ? (c + 4 - r) % 4 : (c + r) % 4);
    return o;
  endfunction

  // Circulant matrix product: M[r][k] = base[(k - r) mod 4].
  function automatic logic [127:0] m_mix(logic [127:0] v, bit inv);
    logic [127:0] o;
    logic [7:0]   base [4];
    logic [7:0]   acc;
    if (inv) begin base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09; end
    else     begin base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gm(base[(k + 4 - r) % 4], bt(v, k, c));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] model(int idx, int nr, bit enc, logic [127:0] blk);
    logic [127:0] s;
    if (enc) begin
      s = blk ^ ks[idx][0];
      for (int rd = 1; rd <= nr; rd++) begin
        s = m_shift(m_sub(s, 0), 0);
        if (rd < nr) s = m_mix(s, 0);
        s = s ^ ks[idx][rd];
      end
    end else begin
      s = blk ^ ks[idx][nr];
      for (int rd = nr - 1; rd >= 1; rd--)
        s = m_mix(m_sub(m_shift(s, 1), 1) ^ ks[idx][rd], 1);
      s = m_sub(m_shift(s, 1), 1) ^ ks[idx][0];
    end
    return s;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, b, cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb[x] = b;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
  endtask

  task automatic expand(int idx, int nr, logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j <= nr; j++) ks[idx][j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    for (int j = nr + 1; j < 15; j++) ks[idx][j] = '0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents a block in the current cycle, follows it to Out_valid and
  // checks Key_idx per cycle, latency and the result against the model.
  task automatic run_block(int s, int nr, bit enc, logic [127:0] blk, output logic [127:0] res);
    int n;
    sel = s;
    in_valid = 1'b1; in_encrypt = enc; in_block = blk;
    #1;
    chk("accept_in_ready", 128'(c_ir), 128'(1));
    chk("key_idx_accept", 128'(c_ki), 128'(enc ? 0 : nr));
    tick();
    in_valid = 1'b0; in_encrypt = ~enc; in_block = rnd128();
    #1;
    n = 1;
    while (!c_ov && n < 40) begin
      chk("busy_round", 128'(c_busy), 128'(1));
      chk("key_idx_round", 128'(c_ki), 128'(enc ? n : nr - n));
      tick();
      n++;
      #1;
    end
    chk("latency", 128'(n), 128'(nr + 1));
    chk("out_valid", 128'(c_ov), 128'(1));
    res = c_ob;
    chk("result_vs_model", res, model(s, nr, enc, blk));
  endtask

  task automatic idle_all();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] key;
    logic [127:0] pt, res, res2, held, blk;
    int ovcnt;
    bit e;

    build_tables();
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    expand(0, 10, key);
    expand(1, 12, key);
    expand(2, 14, key);
    pt = 128'h00112233445566778899aabbccddeeff;

    // Reset state
    #2;
    chk("rst_out_valid", 128'(c_ov), 128'(0));
    chk("rst_out_block", c_ob, 128'(0));
    chk("rst_busy", 128'(c_busy), 128'(0));
    chk("rst_in_ready", 128'(c_ir), 128'(1));
    chk("rst_key_idx_enc", 128'(c_ki), 128'(0));
    in_encrypt = 1'b0;
    #1;
    chk("rst_key_idx_dec", 128'(c_ki), 128'(10));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // NR=10 known answers
    run_block(0, 10, 1, pt, res);
    chk("kat128_enc", res, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    tick();
    chk("out_valid_one_cycle", 128'(c_ov), 128'(0));
    run_block(0, 10, 0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, res);
    chk("kat128_dec", res, pt);
    tick();

    // Backpressure: hold 5 cycles with a pending block, then accept in DONE
    out_ready = 1'b0;
    run_block(0, 10, 1, rnd128(), held);
    in_valid = 1'b1; in_encrypt = 1'b1; in_block = rnd128();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_out_valid", 128'(c_ov), 128'(1));
      chk("bp_out_block", c_ob, held);
      chk("bp_in_ready", 128'(c_ir), 128'(0));
      chk("bp_busy", 128'(c_busy), 128'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_out_valid", 128'(c_ov), 128'(1));
    run_block(0, 10, 0, rnd128(), res);
    tick();

    // Back-to-back alternating encrypt/decrypt
    e = 1'b1;
    run_block(0, 10, e, rnd128(), res);
    for (int i = 0; i < 5; i++) begin
      e = ~e;
      chk("b2b_prev_out_valid", 128'(c_ov), 128'(1));
      run_block(0, 10, e, rnd128(), res);
    end
    tick();
    chk("b2b_drained", 128'(c_ov), 128'(0));

    // Reset during round 5
    idle_all();
    in_valid = 1'b1; in_encrypt = 1'b1; in_block = rnd128();
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #1;
    chk("pre_rst_busy", 128'(c_busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(c_ov), 128'(0));
    chk("mid_rst_out_block", c_ob, 128'(0));
    chk("mid_rst_busy", 128'(c_busy), 128'(0));
    chk("mid_rst_in_ready", 128'(c_ir), 128'(1));
    chk("mid_rst_key_idx", 128'(c_ki), 128'(0));
    tick();
    #2;
    rst_n = 1'b1;
    ovcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (c_ov) ovcnt++;
    end
    chk("no_output_after_abort", 128'(ovcnt), 128'(0));
    blk = rnd128();
    run_block(0, 10, 1, blk, res);
    tick();

    // NR=12 and NR=14
    idle_all();
    run_block(1, 12, 1, pt, res);
    chk("kat192_enc", res, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    tick();
    run_block(1, 12, 0, res, res2);
    chk("kat192_dec", res2, pt);
    tick();
    run_block(1, 12, 0, rnd128(), res);
    idle_all();
    run_block(2, 14, 1, pt, res);
    chk("kat256_enc", res, 128'h8ea2b7ca516745bfeafc49904b496089);
    tick();
    run_block(2, 14, 0, res, res2);
    chk("kat256_dec", res2, pt);
    tick();
    run_block(2, 14, 1, rnd128(), res);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
